// File: rtl/sha256_digest_collector_pkg.sv
// sha256_digest_collector_pkg
//   Shared types and constants for the SHA-256 digest collector slice:
//   the collector FSM state enum and the digest geometry.
package sha256_digest_collector_pkg;

  localparam int DIGEST_WORDS = 8;
  localparam int DIGEST_BYTES = 32;
  localparam int WORD_W       = 32;
  localparam int DIGEST_W     = 256;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

endpackage

// File: rtl/sha256_digest_collector_if.sv
// sha256_digest_collector_if
//   Streaming signals of the collector.
//   hash_in/hash_in_valid : digest words from the SHA-256 core (no backpressure;
//                           a burst is a run of consecutive valid cycles).
//   byte_out/byte_valid/byte_ready : serialized digest bytes toward the host.
//   Handshake: a byte transfers on a rising clk edge where byte_valid and
//   byte_ready are both high. While byte_valid is high and byte_ready low,
//   byte_out holds its value; byte_valid never depends on byte_ready.
//   master : producer of hash words / consumer of bytes (core + host side).
//   slave  : the collector.
interface sha256_digest_collector_if;
  logic [31:0] hash_in;
  logic        hash_in_valid;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;

  modport master (
    output hash_in, hash_in_valid, byte_ready,
    input  byte_out, byte_valid
  );

  modport slave (
    input  hash_in, hash_in_valid, byte_ready,
    output byte_out, byte_valid
  );
endinterface

// File: rtl/sha256_digest_collector_digest_byte_serializer.sv
// digest_byte_serializer
//   Loads a 256-bit digest and presents it as 32 bytes, MSB first, over a
//   valid/ready stream.
//   Ports: clk, rst_n (async active-low), i_load (load i_data, restart at byte 0),
//          i_data (digest), o_byte/o_valid/i_ready (byte stream),
//          o_done (pulse: the final byte is being accepted this cycle).
module digest_byte_serializer
  import sha256_digest_collector_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic [DIGEST_W-1:0] i_data,
  output logic [7:0]          o_byte,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_done
);

  logic [DIGEST_W-1:0] r_data;
  logic [4:0]          r_byte_cnt;
  logic                r_active;

  // Shifting the data left keeps the current byte at the top, which is the
  // same byte as data[255-8*byte_cnt -: 8] on the loaded value. After all 32
  // bytes have gone the register is all zero, so byte_out idles at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_byte_cnt <= '0;
      r_active   <= 1'b0;
    end else if (i_load) begin
      r_data     <= i_data;
      r_byte_cnt <= '0;
      r_active   <= 1'b1;
    end else if (r_active && i_ready) begin
      r_data     <= {r_data[DIGEST_W-9:0], 8'h00};
      r_byte_cnt <= r_byte_cnt + 5'd1;  // wraps to 0 after byte 31
      if (r_byte_cnt == 5'(DIGEST_BYTES - 1)) r_active <= 1'b0;
    end
  end

  assign o_byte  = r_data[DIGEST_W-1 -: 8];
  assign o_valid = r_active;
  assign o_done  = r_active & i_ready & (r_byte_cnt == 5'(DIGEST_BYTES - 1));

endmodule

// File: rtl/sha256_digest_collector.sv
// sha256_digest_collector
//   Captures an 8-word SHA-256 digest burst (MS word first), compares it with
//   an expected digest, then drains it as 32 bytes over a valid/ready stream.
//   Ports: clk, rst_n (async active-low), bus (slave: hash words in, bytes out),
//          expected (golden digest), digest/digest_valid/match (result),
//          busy (FSM not idle), overrun/short_err (sticky errors),
//          clear_err (sync clear of sticky errors), o_state (FSM state, debug).
module sha256_digest_collector
  import sha256_digest_collector_pkg::*;
#(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sha256_digest_collector_if.slave  bus,
  input  logic [DIGEST_W-1:0]       expected,
  output logic [DIGEST_W-1:0]       digest,
  output logic                      digest_valid,
  output logic                      match,
  output logic                      busy,
  output logic                      overrun,
  output logic                      short_err,
  input  logic                      clear_err,
  output state_t                    o_state
);

  state_t              r_state;
  logic                r_prev_valid;
  logic [2:0]          r_word_cnt;
  logic [DIGEST_W-1:0] r_digest;
  logic                r_digest_valid;
  logic                r_match;
  logic                r_overrun;
  logic                r_short_err;

  logic w_burst_start;
  logic w_set_overrun;
  logic w_set_short;
  logic w_load;
  logic w_done;

  assign w_burst_start = bus.hash_in_valid & ~r_prev_valid;
  // A burst that starts while the previous digest is still in use is dropped.
  assign w_set_overrun = w_burst_start & ((r_state == ST_COMPARE) | (r_state == ST_DRAIN));
  assign w_set_short   = (r_state == ST_CAPTURE) & ~bus.hash_in_valid;
  assign w_load        = (r_state == ST_COMPARE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_word_cnt     <= '0;
      r_digest       <= '0;
      r_digest_valid <= 1'b0;
      r_match        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_burst_start) begin
            r_digest[DIGEST_W-1 -: WORD_W] <= bus.hash_in;
            r_word_cnt     <= 3'd1;
            r_digest_valid <= 1'b0;
            r_match        <= 1'b0;
            r_state        <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (bus.hash_in_valid) begin
            for (int w = 0; w < DIGEST_WORDS; w++) begin
              if (r_word_cnt == 3'(w)) r_digest[DIGEST_W-1-WORD_W*w -: WORD_W] <= bus.hash_in;
            end
            r_word_cnt <= r_word_cnt + 3'd1;  // wraps to 0 on the eighth word
            if (r_word_cnt == 3'(DIGEST_WORDS - 1)) r_state <= ST_COMPARE;
          end else begin
            r_word_cnt <= '0;
            r_state    <= ST_IDLE;
          end
        end
        ST_COMPARE: begin
          r_digest_valid <= 1'b1;
          r_match        <= CHECK_EN & (r_digest == expected);
          r_state        <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flags: a setting event in the same cycle as clear_err wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_short_err  <= 1'b0;
    end else begin
      r_prev_valid <= bus.hash_in_valid;
      if (w_set_overrun)  r_overrun <= 1'b1;
      else if (clear_err) r_overrun <= 1'b0;
      if (w_set_short)    r_short_err <= 1'b1;
      else if (clear_err) r_short_err <= 1'b0;
    end
  end

  digest_byte_serializer u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_data  (r_digest),
    .o_byte  (bus.byte_out),
    .o_valid (bus.byte_valid),
    .i_ready (bus.byte_ready),
    .o_done  (w_done)
  );

  assign digest       = r_digest;
  assign digest_valid = r_digest_valid;
  assign match        = r_match;
  assign busy         = (r_state != ST_IDLE);
  assign overrun      = r_overrun;
  assign short_err    = r_short_err;
  assign o_state      = r_state;

endmodule

// File: tb/tb_sha256_digest_collector.sv
// tb_sha256_digest_collector
//   Directed bench for sha256_digest_collector: reset state, matching and
//   mismatching digests, long and short bursts, overrun under backpressure,
//   and asynchronous reset in the middle of a drain.
module tb_sha256_digest_collector;
  import sha256_digest_collector_pkg::*;

  localparam logic [255:0] ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sha256_digest_collector_if bus_if ();

  logic [255:0] expected;
  logic [255:0] digest;
  logic         digest_valid;
  logic         match;
  logic         busy;
  logic         overrun;
  logic         short_err;
  logic         clear_err;
  state_t       state_dbg;

  sha256_digest_collector #(.CHECK_EN(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .expected     (expected),
    .digest       (digest),
    .digest_valid (digest_valid),
    .match        (match),
    .busy         (busy),
    .overrun      (overrun),
    .short_err    (short_err),
    .clear_err    (clear_err),
    .o_state      (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives n consecutive valid cycles; words past the eighth are 0xdeadbeef.
  task automatic send_burst(input logic [255:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.hash_in_valid = 1'b1;
      bus_if.hash_in       = (i < 8) ? d[255-32*i -: 32] : 32'hdeadbeef;
      tick();
    end
    bus_if.hash_in_valid = 1'b0;
    bus_if.hash_in       = '0;
  endtask

  // Scoreboard drain: accepts nbytes bytes and compares each with exp_q.
  // toggle alternates byte_ready 1/0; inject_at >= 0 starts an 8-cycle burst
  // of 0x11111111 on that drain cycle.
  task automatic drain(input logic [255:0] d, input int nbytes, input bit toggle,
                       input int inject_at);
    int         got;
    int         cyc;
    bit         stalled;
    logic [7:0] held;
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    exp_q.delete();
    for (int b = 0; b < 32; b++) exp_q.push_back(d[255-8*b -: 8]);
    while (got < nbytes && cyc < 300) begin
      bus_if.byte_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (inject_at >= 0 && cyc >= inject_at && cyc < inject_at + 8) begin
        bus_if.hash_in_valid = 1'b1;
        bus_if.hash_in       = 32'h11111111;
      end else begin
        bus_if.hash_in_valid = 1'b0;
        bus_if.hash_in       = '0;
      end
      if (stalled) check("byte_stable", bus_if.byte_out, held);
      stalled = bus_if.byte_valid && !bus_if.byte_ready;
      held    = bus_if.byte_out;
      if (bus_if.byte_valid && bus_if.byte_ready) begin
        check($sformatf("byte%0d", got), bus_if.byte_out, exp_q.pop_front());
        got++;
      end
      tick();
      cyc++;
    end
    bus_if.byte_ready    = 1'b0;
    bus_if.hash_in_valid = 1'b0;
    bus_if.hash_in       = '0;
    check("drain_count", got, nbytes);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n                = 1'b0;
    bus_if.hash_in       = '0;
    bus_if.hash_in_valid = 1'b0;
    bus_if.byte_ready    = 1'b0;
    expected             = '0;
    clear_err            = 1'b0;
    repeat (3) tick();

    check("rst_digest",       digest, '0);
    check("rst_digest_valid", digest_valid, 1'b0);
    check("rst_match",        match, 1'b0);
    check("rst_busy",         busy, 1'b0);
    check("rst_byte_valid",   bus_if.byte_valid, 1'b0);
    check("rst_byte_out",     bus_if.byte_out, 8'h00);
    check("rst_overrun",      overrun, 1'b0);
    check("rst_short_err",    short_err, 1'b0);
    check("rst_state",        state_dbg, ST_IDLE);
    rst_n = 1'b1;
    tick();

    // Burst 1: "abc" digest, expected matches.
    expected = ABC;
    send_burst(ABC, 8);
    check("b1_dv_before",   digest_valid, 1'b0);
    check("b1_state_cmp",   state_dbg, ST_COMPARE);
    tick();
    check("b1_dv",          digest_valid, 1'b1);
    check("b1_match",       match, 1'b1);
    check("b1_digest",      digest, ABC);
    check("b1_byte_valid",  bus_if.byte_valid, 1'b1);
    check("b1_byte0",       bus_if.byte_out, 8'hba);
    drain(ABC, 32, 1'b0, -1);
    check("b1_busy_done",   busy, 1'b0);
    check("b1_dv_hold",     digest_valid, 1'b1);
    check("b1_bv_done",     bus_if.byte_valid, 1'b0);

    // Burst 2: expected differs in bit 0.
    expected = ABC ^ 256'd1;
    send_burst(ABC, 8);
    tick();
    check("b2_dv",          digest_valid, 1'b1);
    check("b2_match",       match, 1'b0);
    drain(ABC, 32, 1'b0, -1);
    check("b2_busy_done",   busy, 1'b0);

    // Burst 3: valid held for 10 cycles; extra words ignored.
    expected = ABC;
    send_burst(ABC, 10);
    check("b3_digest",      digest, ABC);
    check("b3_match",       match, 1'b1);
    check("b3_overrun",     overrun, 1'b0);
    check("b3_short",       short_err, 1'b0);
    drain(ABC, 32, 1'b0, -1);
    check("b3_busy_done",   busy, 1'b0);

    // Burst 4: short burst of 5 words, then a full burst, then clear_err.
    send_burst(~ABC, 5);
    tick();
    check("b4_short",       short_err, 1'b1);
    check("b4_dv",          digest_valid, 1'b0);
    check("b4_state",       state_dbg, ST_IDLE);
    check("b4_overrun",     overrun, 1'b0);
    tick();
    send_burst(ABC, 8);
    tick();
    check("b4f_digest",     digest, ABC);
    check("b4f_dv",         digest_valid, 1'b1);
    check("b4f_match",      match, 1'b1);
    check("b4f_short_held", short_err, 1'b1);
    drain(ABC, 32, 1'b0, -1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("b4_short_clr",   short_err, 1'b0);

    // Burst 5: stalling drain with a new burst started mid-drain.
    send_burst(ABC, 8);
    tick();
    drain(ABC, 32, 1'b1, 4);
    check("b5_overrun",     overrun, 1'b1);
    check("b5_digest",      digest, ABC);
    repeat (3) tick();
    check("b5_busy_after",  busy, 1'b0);
    check("b5_dv_after",    digest_valid, 1'b1);
    check("b5_digest_after", digest, ABC);
    check("b5_short",       short_err, 1'b0);

    // Asynchronous reset at drain byte 12, then a clean burst.
    send_burst(ABC, 8);
    tick();
    drain(ABC, 12, 1'b0, -1);
    check("r_busy_pre",     busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("r_digest",       digest, '0);
    check("r_dv",           digest_valid, 1'b0);
    check("r_match",        match, 1'b0);
    check("r_busy",         busy, 1'b0);
    check("r_byte_valid",   bus_if.byte_valid, 1'b0);
    check("r_byte_out",     bus_if.byte_out, 8'h00);
    check("r_overrun",      overrun, 1'b0);
    check("r_short",        short_err, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    send_burst(ABC, 8);
    tick();
    check("pr_dv",          digest_valid, 1'b1);
    check("pr_match",       match, 1'b1);
    check("pr_digest",      digest, ABC);
    drain(ABC, 32, 1'b0, -1);
    check("pr_busy_done",   busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
